// File: rtl/cdc_2ch_arbiter.sv
// ---------------------------------------------------------------------------
// cdc_2ch_arbiter
//
// Shares one byte-processing resource between the two CDC channels of a
// 2-channel loopback design. OUT bytes from both channels are arbitrated
// round-robin with bounded bursts, tagged with their channel ID and
// forwarded through a one-deep output register. Returned bytes are steered
// back to the IN stream of the channel named by their tag. Per-channel
// credit counters cap how many bytes each channel may have inside the shared
// resource, so a stalled IN channel cannot starve its neighbour.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   chN_out_data/valid_i, ready_o OUT byte stream from usb_cdc, channel N
//   shr_data/ch/valid_o, ready_i  tagged byte towards the shared resource
//   shr_data/ch/valid_i, ready_o  tagged byte returned by the shared resource
//   chN_in_data/valid_o, ready_i  IN byte stream to usb_cdc, channel N
//   err_o                         sticky: byte returned with zero outstanding
// ---------------------------------------------------------------------------
module cdc_2ch_arbiter #(
    parameter int MAX_BURST       = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ch0_out_data_i,
    input  logic       ch0_out_valid_i,
    output logic       ch0_out_ready_o,
    input  logic [7:0] ch1_out_data_i,
    input  logic       ch1_out_valid_i,
    output logic       ch1_out_ready_o,
    output logic [7:0] shr_data_o,
    output logic       shr_ch_o,
    output logic       shr_valid_o,
    input  logic       shr_ready_i,
    input  logic [7:0] shr_data_i,
    input  logic       shr_ch_i,
    input  logic       shr_valid_i,
    output logic       shr_ready_o,
    output logic [7:0] ch0_in_data_o,
    output logic       ch0_in_valid_o,
    input  logic       ch0_in_ready_i,
    output logic [7:0] ch1_in_data_o,
    output logic       ch1_in_valid_o,
    input  logic       ch1_in_ready_i,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT0,
        ST_GRANT1
    } state_t;

    localparam int            BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [7:0]    CREDITS   = 8'(MAX_OUTSTANDING);

    // Outstanding counter update: simultaneous issue and return cancel out,
    // and a return with nothing outstanding leaves the counter at zero.
    function automatic logic [7:0] f_cnt_next(input logic [7:0] cnt,
                                              input logic       inc,
                                              input logic       dec);
        logic [7:0] v;
        v = cnt;
        if (inc && !dec)
            v = cnt + 8'd1;
        else if (dec && !inc && cnt != 8'd0)
            v = cnt - 8'd1;
        return v;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_grant;
    logic          w_last_grant_nxt;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_cnt_nxt;
    logic [7:0]    r_out0;
    logic [7:0]    r_out1;
    logic          r_err;
    logic [7:0]    r_shr_data;
    logic          r_shr_ch;
    logic          r_shr_valid;

    logic          w_load_en;
    logic          w_credit0;
    logic          w_credit1;
    logic          w_elig0;
    logic          w_elig1;
    logic          w_fwd0;
    logic          w_fwd1;
    logic          w_fwd_any;
    logic          w_ret0;
    logic          w_ret1;
    logic          w_cur;
    logic          w_own_elig;
    logic          w_oth_elig;
    logic [BW-1:0] w_burst_inc;
    logic          w_burst_full;

    // -----------------------------------------------------------------------
    // Forward side: request qualification and handshakes
    // -----------------------------------------------------------------------
    assign w_load_en = !r_shr_valid || shr_ready_i;
    assign w_credit0 = r_out0 < CREDITS;
    assign w_credit1 = r_out1 < CREDITS;
    assign w_elig0   = ch0_out_valid_i && w_credit0;
    assign w_elig1   = ch1_out_valid_i && w_credit1;

    assign ch0_out_ready_o = w_load_en && (r_state == ST_GRANT0) && w_credit0;
    assign ch1_out_ready_o = w_load_en && (r_state == ST_GRANT1) && w_credit1;

    assign w_fwd0    = ch0_out_valid_i && ch0_out_ready_o;
    assign w_fwd1    = ch1_out_valid_i && ch1_out_ready_o;
    assign w_fwd_any = w_fwd0 || w_fwd1;

    // Grant-relative view so both GRANT states share one set of rules.
    assign w_cur      = (r_state == ST_GRANT1);
    assign w_own_elig = w_cur ? w_elig1 : w_elig0;
    assign w_oth_elig = w_cur ? w_elig0 : w_elig1;

    // Burst limit counts the handshake happening in this very cycle.
    assign w_burst_inc  = r_burst_cnt + BW'(w_fwd_any);
    assign w_burst_full = w_fwd_any && (w_burst_inc == BURST_MAX);

    // -----------------------------------------------------------------------
    // Return side: pure steering, a stalled IN channel blocks the path
    // -----------------------------------------------------------------------
    assign ch0_in_data_o  = shr_data_i;
    assign ch1_in_data_o  = shr_data_i;
    assign ch0_in_valid_o = shr_valid_i && !shr_ch_i;
    assign ch1_in_valid_o = shr_valid_i && shr_ch_i;
    assign shr_ready_o    = shr_ch_i ? ch1_in_ready_i : ch0_in_ready_i;

    assign w_ret0 = ch0_in_valid_o && ch0_in_ready_i;
    assign w_ret1 = ch1_in_valid_o && ch1_in_ready_i;

    // -----------------------------------------------------------------------
    // Arbiter next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_burst_cnt_nxt  = r_burst_cnt;

        unique case (r_state)
            ST_IDLE: begin
                w_burst_cnt_nxt = '0;
                if (w_elig0 && w_elig1)
                    w_state_nxt = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                else if (w_elig0)
                    w_state_nxt = ST_GRANT0;
                else if (w_elig1)
                    w_state_nxt = ST_GRANT1;
            end

            ST_GRANT0, ST_GRANT1: begin
                if (!w_own_elig || (w_burst_full && w_oth_elig)) begin
                    if (w_oth_elig)
                        w_state_nxt = w_cur ? ST_GRANT0 : ST_GRANT1;
                    else
                        w_state_nxt = ST_IDLE;
                    w_last_grant_nxt = w_cur;
                    w_burst_cnt_nxt  = '0;
                end else if (w_burst_full) begin
                    // Nobody else wants the resource: keep the grant and
                    // start a fresh burst.
                    w_burst_cnt_nxt = '0;
                end else begin
                    w_burst_cnt_nxt = w_burst_inc;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, output register, credit counters, error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
            r_out0       <= 8'd0;
            r_out1       <= 8'd0;
            r_err        <= 1'b0;
            r_shr_data   <= 8'd0;
            r_shr_ch     <= 1'b0;
            r_shr_valid  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, regardless of statement order.
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;

            if (w_load_en) begin
                if (w_fwd0) begin
                    r_shr_data  <= ch0_out_data_i;
                    r_shr_ch    <= 1'b0;
                    r_shr_valid <= 1'b1;
                end else if (w_fwd1) begin
                    r_shr_data  <= ch1_out_data_i;
                    r_shr_ch    <= 1'b1;
                    r_shr_valid <= 1'b1;
                end else begin
                    r_shr_valid <= 1'b0;
                end
            end

            r_out0 <= f_cnt_next(r_out0, w_fwd0, w_ret0);
            r_out1 <= f_cnt_next(r_out1, w_fwd1, w_ret1);

            if ((w_ret0 && r_out0 == 8'd0) || (w_ret1 && r_out1 == 8'd0))
                r_err <= 1'b1;
        end
    end

    assign shr_data_o  = r_shr_data;
    assign shr_ch_o    = r_shr_ch;
    assign shr_valid_o = r_shr_valid;
    assign err_o       = r_err;

endmodule

// File: tb/tb_cdc_2ch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdc_2ch_arbiter
//
// Directed bench for cdc_2ch_arbiter. Byte sources, a FIFO-style shared
// resource and the IN sinks are modelled with queues. A transaction-level
// model (credit counts, sticky error, expected forward byte, grant order
// derived from the round-robin/burst rules) is checked against the DUT on
// every negative clock edge; each scenario ends with stream and literal
// checks.
// ---------------------------------------------------------------------------
module tb_cdc_2ch_arbiter;

    localparam int MAX_BURST = 8;
    localparam int MAX_OUT   = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] ch0_out_data_i = 8'h00;
    logic       ch0_out_valid_i = 1'b0;
    logic       ch0_out_ready_o;
    logic [7:0] ch1_out_data_i = 8'h00;
    logic       ch1_out_valid_i = 1'b0;
    logic       ch1_out_ready_o;
    logic [7:0] shr_data_o;
    logic       shr_ch_o;
    logic       shr_valid_o;
    logic       shr_ready_i = 1'b1;
    logic [7:0] shr_data_i = 8'h00;
    logic       shr_ch_i = 1'b0;
    logic       shr_valid_i = 1'b0;
    logic       shr_ready_o;
    logic [7:0] ch0_in_data_o;
    logic       ch0_in_valid_o;
    logic       ch0_in_ready_i = 1'b1;
    logic [7:0] ch1_in_data_o;
    logic       ch1_in_valid_o;
    logic       ch1_in_ready_i = 1'b1;
    logic       err_o;

    cdc_2ch_arbiter #(
        .MAX_BURST      (MAX_BURST),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ch0_out_data_i (ch0_out_data_i),
        .ch0_out_valid_i(ch0_out_valid_i),
        .ch0_out_ready_o(ch0_out_ready_o),
        .ch1_out_data_i (ch1_out_data_i),
        .ch1_out_valid_i(ch1_out_valid_i),
        .ch1_out_ready_o(ch1_out_ready_o),
        .shr_data_o     (shr_data_o),
        .shr_ch_o       (shr_ch_o),
        .shr_valid_o    (shr_valid_o),
        .shr_ready_i    (shr_ready_i),
        .shr_data_i     (shr_data_i),
        .shr_ch_i       (shr_ch_i),
        .shr_valid_i    (shr_valid_i),
        .shr_ready_o    (shr_ready_o),
        .ch0_in_data_o  (ch0_in_data_o),
        .ch0_in_valid_o (ch0_in_valid_o),
        .ch0_in_ready_i (ch0_in_ready_i),
        .ch1_in_data_o  (ch1_in_data_o),
        .ch1_in_valid_o (ch1_in_valid_o),
        .ch1_in_ready_i (ch1_in_ready_i),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard / model state
    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    logic [7:0] sent0_q[$];
    logic [7:0] sent1_q[$];
    logic [7:0] got0_q[$];
    logic [7:0] got1_q[$];
    logic [8:0] res_q[$];
    logic       tag_q[$];
    logic       exp_tag[$];
    int         mdl_out[2];
    logic       mdl_err   = 1'b0;
    logic       exp_pend  = 1'b0;
    logic [8:0] exp_item  = 9'h0;
    logic       tgl_mode  = 1'b0;
    logic       chk_en    = 1'b0;
    int         n_fwd0    = 0;
    int         n_fwd1    = 0;
    int         n_checks  = 0;
    int         n_errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present the heads of the source and resource queues.
    task automatic drive();
        ch0_out_valid_i = (src0_q.size() != 0);
        ch0_out_data_i  = (src0_q.size() != 0) ? src0_q[0] : 8'h00;
        ch1_out_valid_i = (src1_q.size() != 0);
        ch1_out_data_i  = (src1_q.size() != 0) ? src1_q[0] : 8'h00;
        shr_valid_i     = (res_q.size() != 0);
        {shr_ch_i, shr_data_i} = (res_q.size() != 0) ? res_q[0] : 9'h0;
    endtask

    // One clock: sample handshakes at the edge, update the models, redrive.
    task automatic cycle();
        logic       f0, f1, acc, ret, rch;
        logic [8:0] acc_item;
        logic [7:0] rdata;
        @(posedge clk_i);
        f0       = ch0_out_valid_i && ch0_out_ready_o;
        f1       = ch1_out_valid_i && ch1_out_ready_o;
        acc      = shr_valid_o && shr_ready_i;
        acc_item = {shr_ch_o, shr_data_o};
        ret      = shr_valid_i && shr_ready_o;
        rch      = shr_ch_i;
        rdata    = shr_data_i;
        #1;
        exp_pend = f0 || f1;
        if (ret) begin
            void'(res_q.pop_front());
            if (rch) got1_q.push_back(rdata);
            else     got0_q.push_back(rdata);
            if (mdl_out[rch] == 0) mdl_err = 1'b1;
            else                   mdl_out[rch]--;
        end
        if (f0) begin
            exp_item = {1'b0, src0_q.pop_front()};
            mdl_out[0]++;
            tag_q.push_back(1'b0);
            n_fwd0++;
        end
        if (f1) begin
            exp_item = {1'b1, src1_q.pop_front()};
            mdl_out[1]++;
            tag_q.push_back(1'b1);
            n_fwd1++;
        end
        if (acc) res_q.push_back(acc_item);
        shr_ready_i = tgl_mode ? ~shr_ready_i : 1'b1;
        drive();
    endtask

    task automatic load(input int ch, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) begin src0_q.push_back(base + 8'(i)); sent0_q.push_back(base + 8'(i)); end
            else         begin src1_q.push_back(base + 8'(i)); sent1_q.push_back(base + 8'(i)); end
        end
    endtask

    task automatic clear_sb();
        sent0_q.delete(); sent1_q.delete();
        got0_q.delete();  got1_q.delete();
        tag_q.delete();
        n_fwd0 = 0;
        n_fwd1 = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 || res_q.size() != 0 || shr_valid_o)
               && n < budget) begin
            cycle();
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    task automatic check_got(input string name, input int ch);
        int bad;
        bad = 0;
        if (ch == 0) begin
            check({name, "_count"}, got0_q.size(), sent0_q.size());
            foreach (got0_q[i]) if (i < sent0_q.size() && got0_q[i] !== sent0_q[i]) bad++;
        end else begin
            check({name, "_count"}, got1_q.size(), sent1_q.size());
            foreach (got1_q[i]) if (i < sent1_q.size() && got1_q[i] !== sent1_q[i]) bad++;
        end
        check({name, "_order"}, bad, 0);
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    logic       hold_pend = 1'b0;
    logic [8:0] hold_item = 9'h0;

    always @(negedge clk_i) begin
        if (chk_en && !rst_i) begin
            check("ch0_in_valid", ch0_in_valid_o, shr_valid_i && !shr_ch_i);
            check("ch1_in_valid", ch1_in_valid_o, shr_valid_i && shr_ch_i);
            check("ch0_in_data", ch0_in_data_o, shr_data_i);
            check("ch1_in_data", ch1_in_data_o, shr_data_i);
            check("shr_ready_o", shr_ready_o, shr_ch_i ? ch1_in_ready_i : ch0_in_ready_i);
            check("err_o", err_o, mdl_err);
            check("single_grant", ch0_out_ready_o && ch1_out_ready_o, 0);
            if (mdl_out[0] >= MAX_OUT) check("ch0_credit_block", ch0_out_ready_o, 0);
            if (mdl_out[1] >= MAX_OUT) check("ch1_credit_block", ch1_out_ready_o, 0);
            if (shr_valid_o && !shr_ready_i)
                check("ready_while_stalled", ch0_out_ready_o || ch1_out_ready_o, 0);
            if (exp_pend)
                check("fwd_latency", {shr_valid_o, shr_ch_o, shr_data_o}, {1'b1, exp_item});
            if (hold_pend)
                check("hold_stable", {shr_valid_o, shr_ch_o, shr_data_o}, {1'b1, hold_item});
            hold_pend = shr_valid_o && !shr_ready_i;
            hold_item = {shr_ch_o, shr_data_o};
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        int rem[2];
        int turn;
        int bad;
        int n;
        mdl_out[0] = 0;
        mdl_out[1] = 0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk_en = 1'b1;
        check("rst_shr_valid", shr_valid_o, 0);
        check("rst_shr_data", shr_data_o, 8'h00);
        check("rst_shr_ch", shr_ch_o, 0);
        check("rst_err", err_o, 0);
        check("rst_idle_ready", {ch0_out_ready_o, ch1_out_ready_o}, 2'b00);

        // ---------------- fairness ----------------
        clear_sb();
        load(0, 8'h41, 20);
        load(1, 8'h81, 20);
        drive();
        drain("fair_drain", 400);
        exp_tag.delete();
        rem[0] = 20;
        rem[1] = 20;
        turn   = 0;
        while (rem[0] + rem[1] > 0) begin
            if (rem[turn] > 0) begin
                n = (rem[turn] < MAX_BURST) ? rem[turn] : MAX_BURST;
                repeat (n) exp_tag.push_back(turn[0]);
                rem[turn] -= n;
            end
            turn = 1 - turn;
        end
        check("fair_model_len", exp_tag.size(), 40);
        check("fair_len", tag_q.size(), exp_tag.size());
        bad = 0;
        foreach (tag_q[i]) if (i < exp_tag.size() && tag_q[i] !== exp_tag[i]) bad++;
        check("fair_order", bad, 0);
        check("fair_first_ch0", tag_q[0], 0);
        check("fair_tag8_ch1", tag_q[8], 1);
        check("fair_tag16_ch0", tag_q[16], 0);
        check("fair_tag35_ch0", tag_q[35], 0);
        check("fair_tag36_ch1", tag_q[36], 1);
        check_got("fair_ch0", 0);
        check_got("fair_ch1", 1);

        // ---------------- single channel ----------------
        clear_sb();
        load(0, 8'h01, 7);
        drive();
        drain("single_drain", 200);
        check_got("single_ch0", 0);
        check("single_ch1_none", got1_q.size(), 0);
        check("single_fwd0", n_fwd0, 7);
        check("single_out0_zero", mdl_out[0], 0);

        // ---------------- credit limit ----------------
        clear_sb();
        ch1_in_ready_i = 1'b0;
        load(1, 8'hC1, 20);
        drive();
        repeat (60) cycle();
        check("credit_fwd1", n_fwd1, 16);
        check("credit_ready_low", {ch1_out_valid_i, ch1_out_ready_o}, 2'b10);
        load(0, 8'h21, 5);
        drive();
        repeat (30) cycle();
        check("credit_fwd0", n_fwd0, 5);
        check("credit_hol_ch0", got0_q.size(), 0);
        check("credit_hol_ch1", got1_q.size(), 0);
        ch1_in_ready_i = 1'b1;
        drain("credit_drain", 400);
        check_got("credit_ch0", 0);
        check_got("credit_ch1", 1);

        // ---------------- backpressure ----------------
        clear_sb();
        tgl_mode = 1'b1;
        load(0, 8'h60, 16);
        drive();
        drain("bp_drain", 300);
        tgl_mode = 1'b0;
        check_got("bp_ch0", 0);
        check("bp_fwd0", n_fwd0, 16);

        // ---------------- error ----------------
        clear_sb();
        res_q.push_back({1'b1, 8'h55});
        drive();
        repeat (3) cycle();
        check("err_set", err_o, 1);
        check("err_byte_count", got1_q.size(), 1);
        check("err_byte_value", got1_q[0], 8'h55);
        repeat (5) cycle();
        check("err_sticky", err_o, 1);

        // ---------------- async reset mid-burst ----------------
        clear_sb();
        load(0, 8'h91, 8);
        drive();
        n = 0;
        while (n_fwd0 < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("rst_mid_setup", n_fwd0, 3);
        check("rst_mid_busy", shr_valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_valid", shr_valid_o, 0);
        check("rst_mid_err", err_o, 0);
        src0_q.delete();
        src1_q.delete();
        res_q.delete();
        clear_sb();
        mdl_out[0] = 0;
        mdl_out[1] = 0;
        mdl_err    = 1'b0;
        drive();
        repeat (2) cycle();
        rst_i = 1'b0;
        load(0, 8'hA1, 3);
        load(1, 8'hB1, 3);
        drive();
        drain("rst_after_drain", 200);
        check("rst_after_first_ch0", tag_q[0], 0);
        check("rst_after_len", tag_q.size(), 6);
        check_got("rst_after_ch0", 0);
        check_got("rst_after_ch1", 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdc_2ch_arbiter.md
Name: cdc_2ch_arbiter

Overview:
- Shares one byte-processing resource between the two CDC channels of the 2-channel loopback design.
- Takes the OUT byte streams of both channels (usb_cdc application side), arbitrates round-robin with bounded bursts and forwards bytes tagged with their channel ID.
- Steers returned bytes back to the matching channel's IN stream.
- Per-channel credit counters stop one stalled channel from monopolising the shared resource.

Parameters:
- MAX_BURST, 8: max consecutive bytes granted to one channel while the other requests (matches bulk max packet size).
- MAX_OUTSTANDING, 16: max bytes per channel issued to the shared resource and not yet returned; range 1..255.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- ch0_out_data_i  input  8  channel 0 byte from usb_cdc OUT.
- ch0_out_valid_i  input  1  channel 0 byte valid.
- ch0_out_ready_o  output  1  channel 0 byte accepted.
- ch1_out_data_i / ch1_out_valid_i / ch1_out_ready_o  in/in/out  8/1/1  same for channel 1.
- shr_data_o  output  8  byte to shared resource.
- shr_ch_o  output  1  channel tag of shr_data_o.
- shr_valid_o  output  1  shr_data_o valid.
- shr_ready_i  input  1  shared resource accepts.
- shr_data_i  input  8  returned byte.
- shr_ch_i  input  1  channel tag of returned byte.
- shr_valid_i  input  1  returned byte valid.
- shr_ready_o  output  1  returned byte accepted.
- ch0_in_data_o / ch0_in_valid_o / ch0_in_ready_i  out/out/in  8/1/1  channel 0 usb_cdc IN stream.
- ch1_in_data_o / ch1_in_valid_o / ch1_in_ready_i  out/out/in  8/1/1  channel 1 usb_cdc IN stream.
- err_o  output  1  sticky: byte returned for a channel with zero outstanding.

Behaviour:
- Handshake: a transfer occurs on a cycle where valid and ready are both high. Valid must not depend on ready. Data and tag stay stable while valid is high and not yet accepted.
- Reset (async assert, sync release): state IDLE, last_grant=1 (so channel 0 wins first), burst_cnt=0, both outstanding counters 0, shr_valid_o=0, shr_data_o=0, shr_ch_o=0, err_o=0.
- Forward output register:
  - shr_data_o/shr_ch_o/shr_valid_o are registered.
  - load_en = !shr_valid_o || shr_ready_i.
  - chN_out_ready_o = load_en && state==GRANTn && outstanding_n < MAX_OUTSTANDING (combinational).
  - On a chN handshake the register loads the byte, shr_ch_o=N and shr_valid_o=1, so latency is 1 cycle.
  - If load_en is high with no handshake, shr_valid_o drops to 0.
- Eligibility: chN is eligible when chN_out_valid_i=1 and outstanding_n < MAX_OUTSTANDING.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: if both channels are eligible, go to GRANT of the channel that is not last_grant; else go to GRANT of the single eligible channel; else stay in IDLE. burst_cnt clears on entry to any GRANT.
  - GRANTn: each chN handshake increments burst_cnt.
  - Leave GRANTn when chN is not eligible, or when burst_cnt reaches MAX_BURST (that cycle's handshake included) and the other channel is eligible.
  - On leaving: go to GRANT of the other channel if it is eligible, else IDLE; set last_grant=n.
  - Reaching MAX_BURST with the other channel not eligible: stay in GRANTn and clear burst_cnt.
  - State change takes effect the next cycle; one idle cycle between grants is allowed.
- Return path (combinational):
  - chN_in_data_o = shr_data_i.
  - chN_in_valid_o = shr_valid_i && shr_ch_i==N.
  - shr_ready_o = ch[shr_ch_i]_in_ready_i.
  - A stalled IN channel blocks the return path (head-of-line). The credit limit bounds the impact.
- Outstanding counters (8 bit):
  - Increment on a chN forward handshake; decrement on a chN return handshake; both on the same channel in the same cycle leaves the counter unchanged.
  - A return with outstanding 0: counter stays 0, err_o set until reset, byte still delivered.
- Reset mid-operation: all state discarded; any byte in the output register is lost.

Test Plan:
- Single channel: ch0 sends 0x01..0x07, shared resource is a loopback with ready=1 → shr_ch_o=0 for all bytes, bytes appear on ch0_in 0x01..0x07 in order, ch1_in_valid_o never 1, outstanding returns to 0.
- Fairness: both channels hold valid continuously with 20 bytes each (ch0 0x41.., ch1 0x81..) → shr sequence is 8×ch0, 8×ch1, 8×ch0, 8×ch1, 4×ch0, 4×ch1; ch0 is granted first after reset.
- Credit limit: ch1_in_ready_i=0 while ch1 sends 20 bytes and ch0 sends 5 → ch1_out_ready_o stops after 16 accepted bytes. Returned ch1 bytes then block the return path until ch1_in_ready_i=1, after which all 20 ch1 bytes and 5 ch0 bytes arrive in order.
- Backpressure: shr_ready_i toggles 1/0 every cycle during a 16-byte ch0 burst → no byte lost or duplicated, shr_data_o stable while shr_valid_o=1 and shr_ready_i=0.
- Error: inject return byte 0x55 tagged ch1 with no outstanding → err_o=1 the next cycle and stays 1, ch1_in receives 0x55.
- Async reset asserted mid-burst after 3 of 8 bytes → shr_valid_o=0 and err_o=0 immediately; after release ch0 wins the first grant again.
